// File: rtl/fifo_reader_if.sv
// Pop-side FIFO hookup and output stream bundle for fifo_reader.
// master = the reader itself, slave = the FIFO/consumer environment.
interface fifo_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_pop_o;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_empty_i;
  logic             flush_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             ready_i;
  logic [1:0]       level_o;

  modport master (
    output fifo_pop_o,
    output valid_o,
    output data_o,
    output level_o,
    input  fifo_data_i,
    input  fifo_empty_i,
    input  flush_i,
    input  ready_i
  );

  modport slave (
    input  fifo_pop_o,
    input  valid_o,
    input  data_o,
    input  level_o,
    output fifo_data_i,
    output fifo_empty_i,
    output flush_i,
    output ready_i
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: pops a registered-read FIFO and re-presents its words as a
// valid/ready stream. A 2-entry buffer absorbs the one-cycle read latency so
// the stream can run at one word per cycle. Buffer occupancy plus the word in
// flight never exceeds 2, so a captured word always has a free slot.
module fifo_reader #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fifo_reader_if.master bus
);

  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] tail_q;
  logic [WIDTH-1:0] tail_d;
  logic             deq;
  logic             cap;
  logic             pop;
  logic [1:0]       occupancy;

  assign bus.valid_o = (count_q != 2'd0);
  assign bus.data_o  = head_q;
  assign bus.level_o = count_q;

  assign deq = bus.valid_o && bus.ready_i;
  // A word arriving during a flush is dropped rather than captured.
  assign cap = inflight_q && !bus.flush_i;

  // Committed slots after this cycle's dequeue, counting the word in flight.
  assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, deq};

  // Pop only when a slot is guaranteed free; reset holds the pop low even
  // between clock edges.
  assign pop = !rst_i && !bus.fifo_empty_i && !bus.flush_i && (occupancy < 2'd2);
  assign bus.fifo_pop_o = pop;

  // Buffer update: capture goes to the first free slot, dequeue shifts tail to head.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({cap, deq})
        2'b10: begin
          if (count_q == 2'd0) head_d = bus.fifo_data_i;
          else                 tail_d = bus.fifo_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = bus.fifo_data_i;
          end else begin
            head_d = bus.fifo_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= pop;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO with one-cycle read latency
// drives the DUT; a scoreboard of popped-but-unconsumed words predicts
// pop, level, valid and the order of delivered words.
module tb_fifo_reader;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_reader #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pops_seen = 0;

  logic [WIDTH-1:0] fq[$];   // words still in the FIFO
  logic [WIDTH-1:0] sb[$];   // words popped (in flight or buffered), oldest first
  logic             prev_pop;

  logic             obs_pop;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;
  logic [1:0]       obs_level;
  logic [WIDTH-1:0] resume_head;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    bus.fifo_empty_i = 1'b0;
  endtask

  // One clock cycle: apply ready/flush, sample and check at the falling edge,
  // then advance the FIFO model just after the rising edge.
  task automatic cycle(input logic rdy, input logic fl);
    logic deq;
    logic exp_pop;
    int   occ;
    int   exp_level;
    bus.ready_i = rdy;
    bus.flush_i = fl;
    @(negedge clk);
    obs_pop   = bus.fifo_pop_o;
    obs_valid = bus.valid_o;
    obs_data  = bus.data_o;
    obs_level = bus.level_o;
    deq       = obs_valid && rdy;
    occ       = sb.size() - (deq ? 1 : 0);
    exp_pop   = !rst && (fq.size() != 0) && !fl && (occ < 2);
    exp_level = rst ? 0 : sb.size() - int'(prev_pop);
    check("pop", WIDTH'(obs_pop), WIDTH'(exp_pop));
    check("level", WIDTH'(obs_level), WIDTH'(exp_level));
    check("valid", WIDTH'(obs_valid), WIDTH'(exp_level != 0));
    if (deq) begin
      if (sb.size() == 0) begin
        check("spurious_word", WIDTH'(obs_valid), WIDTH'(0));
      end else begin
        check("order", obs_data, sb[0]);
        void'(sb.pop_front());
      end
    end
    if (fl) sb.delete();
    prev_pop = obs_pop;
    if (obs_pop) pops_seen++;
    @(posedge clk);
    #1;
    if (obs_pop && !rst && fq.size() != 0) begin
      bus.fifo_data_i = fq.pop_front();
      sb.push_back(bus.fifo_data_i);
    end
    bus.fifo_empty_i = (fq.size() == 0);
  endtask

  initial begin
    logic [WIDTH-1:0] t3_data [7];
    logic             t3_pop  [7];
    logic             t3_valid[7];
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i  = '0;
    bus.ready_i      = 1'b0;
    bus.flush_i      = 1'b0;
    prev_pop         = 1'b0;

    // Reset held with the FIFO empty.
    repeat (5) cycle(1'b0, 1'b0);
    check("rst_data", obs_data, WIDTH'(0));
    rst = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);
    check("idle_no_pop", WIDTH'(pops_seen), WIDTH'(0));

    // Single word: pop now, valid two cycles later, gone the cycle after.
    push(32'd10);
    pops_seen = 0;
    cycle(1'b1, 1'b0);
    check("t2_pop", WIDTH'(obs_pop), WIDTH'(1));
    cycle(1'b1, 1'b0);
    check("t2_valid_early", WIDTH'(obs_valid), WIDTH'(0));
    cycle(1'b1, 1'b0);
    check("t2_valid", WIDTH'(obs_valid), WIDTH'(1));
    check("t2_data", obs_data, 32'd10);
    cycle(1'b1, 1'b0);
    check("t2_valid_after", WIDTH'(obs_valid), WIDTH'(0));
    check("t2_pops", WIDTH'(pops_seen), WIDTH'(1));

    // Back-to-back burst at full throughput.
    t3_pop   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t3_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t3_data  = '{32'd0, 32'd0, 32'd10, 32'd12, 32'd14, 32'd16, 32'd0};
    push(32'd10); push(32'd12); push(32'd14); push(32'd16);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0);
      check("t3_pop", WIDTH'(obs_pop), WIDTH'(t3_pop[i]));
      check("t3_valid", WIDTH'(obs_valid), WIDTH'(t3_valid[i]));
      if (t3_valid[i]) check("t3_data", obs_data, t3_data[i]);
    end

    // Backpressure: buffer saturates at 2, then drains with no gap.
    push(32'd10); push(32'd12); push(32'd14); push(32'd16);
    pops_seen = 0;
    repeat (5) cycle(1'b0, 1'b0);
    check("t4_level", WIDTH'(obs_level), WIDTH'(2));
    check("t4_pops", WIDTH'(pops_seen), WIDTH'(2));
    check("t4_fifo_left", WIDTH'(fq.size()), WIDTH'(2));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      check("t4_valid", WIDTH'(obs_valid), WIDTH'(1));
      check("t4_data", obs_data, WIDTH'(10 + 2 * i));
    end
    cycle(1'b1, 1'b0);
    check("t4_valid_end", WIDTH'(obs_valid), WIDTH'(0));

    // Flush with one word buffered and one in flight.
    push(32'd10); push(32'd12); push(32'd14); push(32'd16);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("t5_full", WIDTH'(obs_level), WIDTH'(2));
    check("t5_pop14", WIDTH'(obs_pop), WIDTH'(1));
    cycle(1'b0, 1'b1);
    check("t5_flush_pop", WIDTH'(obs_pop), WIDTH'(0));
    cycle(1'b1, 1'b0);
    check("t5_valid_cleared", WIDTH'(obs_valid), WIDTH'(0));
    check("t5_level_cleared", WIDTH'(obs_level), WIDTH'(0));
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("t5_next_valid", WIDTH'(obs_valid), WIDTH'(1));
    check("t5_next_data", obs_data, 32'd16);
    cycle(1'b1, 1'b0);

    // Asynchronous reset between edges mid-stream.
    for (int i = 0; i < 6; i++) push(WIDTH'(20 + i));
    repeat (3) cycle(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid_async", WIDTH'(bus.valid_o), WIDTH'(0));
    check("t6_pop_async", WIDTH'(bus.fifo_pop_o), WIDTH'(0));
    check("t6_level_async", WIDTH'(bus.level_o), WIDTH'(0));
    sb.delete();
    prev_pop = 1'b0;
    repeat (2) cycle(1'b1, 1'b0);
    rst = 1'b0;
    resume_head = fq[0];
    repeat (3) cycle(1'b1, 1'b0);
    check("t6_resume_valid", WIDTH'(obs_valid), WIDTH'(1));
    check("t6_resume_data", obs_data, resume_head);
    for (int i = 0; i < 20 && (fq.size() != 0 || sb.size() != 0); i++) cycle(1'b1, 1'b0);

    // Random traffic with backpressure and occasional flushes.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) push($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 400 && (fq.size() != 0 || sb.size() != 0); i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("drain_sb", WIDTH'(sb.size()), WIDTH'(0));
    check("drain_fifo", WIDTH'(fq.size()), WIDTH'(0));
    check("drain_valid", WIDTH'(obs_valid), WIDTH'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
